// File: rtl/key_event_scheduler.sv
// -----------------------------------------------------------------------------
// key_event_scheduler
//
// Collects one-cycle event strobes from three sources (keys, encoders, patient
// button) into per-source hold registers and moves them, one per cycle, into
// a first-word-fall-through event queue that the host drains. A round-robin
// arbiter picks which full hold register is written to the queue. Strobes
// that find their hold register still occupied are dropped and counted.
//
// Ports
//   clk         in   1        clock
//   rst         in   1        asynchronous active-high reset
//   src_pulse   in   3        event strobes: bit0 keys, bit1 encoders,
//                             bit2 patient button
//   src_code    in   24       event codes, source i in bits [8i+7:8i]
//   ev_valid    out  1        queue head holds an event
//   ev_code     out  8        queue head code (8'h00 when empty)
//   ev_ack      in   1        host consumed the head event
//   irq         out  1        registered interrupt, high while queue non-empty
//   fifo_level  out  AW+1     queue occupancy
//   ovf_cnt     out  8        dropped-event counter, saturates at 255
//   clr_ovf     in   1        synchronous clear of ovf_cnt
// -----------------------------------------------------------------------------
module key_event_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    src_pulse,
  input  logic [23:0]   src_code,
  output logic          ev_valid,
  output logic [7:0]    ev_code,
  input  logic          ev_ack,
  output logic          irq,
  output logic [AW:0]   fifo_level,
  output logic [7:0]    ovf_cnt,
  input  logic          clr_ovf
);

  localparam logic [AW:0] LP_DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LP_LVL_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] LP_LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] LP_PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  // Next source in the modulo-3 rotation (0 -> 1 -> 2 -> 0).
  function automatic logic [1:0] inc3(input logic [1:0] a);
    logic [1:0] r;
    case (a)
      2'd0:    r = 2'd1;
      2'd1:    r = 2'd2;
      2'd2:    r = 2'd0;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]        r_full;
  logic [2:0][7:0]   r_hold;
  logic [1:0]        r_ptr;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              r_irq;
  logic [7:0]        r_ovf;

  // ---------------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------------
  logic              w_pop;
  logic              w_space;
  logic [1:0]        w_cand0;
  logic [1:0]        w_cand1;
  logic [1:0]        w_cand2;
  logic [2:0]        w_grant_vec;
  logic [1:0]        w_grant_idx;
  logic              w_push;
  logic [7:0]        w_grant_code;
  logic [2:0]        w_drop_vec;
  logic [1:0]        w_drop_cnt;
  logic [8:0]        w_ovf_sum;
  logic [7:0]        w_ovf_next;
  logic [AW:0]       w_level_next;

  // A pop only happens when there is something to pop; an ack on an empty
  // queue is ignored. A full queue still accepts a push when it pops the
  // same cycle, so the slot freed at the head is reused at the tail.
  assign w_pop   = ev_ack && (r_level != LP_LVL_ZERO);
  assign w_space = (r_level != LP_DEPTH) || w_pop;

  // Search order after the last granted source: ptr+1, ptr+2, ptr.
  assign w_cand0 = inc3(r_ptr);
  assign w_cand1 = inc3(w_cand0);
  assign w_cand2 = inc3(w_cand1);

  // Round-robin arbiter: first full hold register in search order wins.
  always_comb begin
    w_grant_vec = 3'b000;
    w_grant_idx = 2'd0;
    if (w_space && r_full[w_cand0]) begin
      w_grant_vec[w_cand0] = 1'b1;
      w_grant_idx          = w_cand0;
    end else if (w_space && r_full[w_cand1]) begin
      w_grant_vec[w_cand1] = 1'b1;
      w_grant_idx          = w_cand1;
    end else if (w_space && r_full[w_cand2]) begin
      w_grant_vec[w_cand2] = 1'b1;
      w_grant_idx          = w_cand2;
    end else begin
      w_grant_vec = 3'b000;
      w_grant_idx = 2'd0;
    end
  end

  assign w_push = |w_grant_vec;

  // Code of the granted hold register, written to the queue tail.
  always_comb begin
    w_grant_code = 8'h00;
    case (w_grant_idx)
      2'd0:    w_grant_code = r_hold[0];
      2'd1:    w_grant_code = r_hold[1];
      2'd2:    w_grant_code = r_hold[2];
      default: w_grant_code = 8'h00;
    endcase
  end

  // A strobe is dropped when its hold register is occupied and is not being
  // emptied by a grant in the same cycle.
  assign w_drop_vec = src_pulse & r_full & ~w_grant_vec;
  assign w_drop_cnt = {1'b0, w_drop_vec[0]} + {1'b0, w_drop_vec[1]} + {1'b0, w_drop_vec[2]};
  assign w_ovf_sum  = {1'b0, r_ovf} + {7'b0000000, w_drop_cnt};

  // Overflow counter update: clear replaces the count with this cycle's drops.
  always_comb begin
    w_ovf_next = r_ovf;
    if (clr_ovf) begin
      w_ovf_next = {6'b000000, w_drop_cnt};
    end else if (w_ovf_sum[8]) begin
      w_ovf_next = 8'hFF;
    end else begin
      w_ovf_next = w_ovf_sum[7:0];
    end
  end

  // Occupancy update; simultaneous push and pop cancel out.
  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LP_LVL_ONE;
      2'b01:   w_level_next = r_level - LP_LVL_ONE;
      default: w_level_next = r_level;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Hold registers and full flags: load on an accepted strobe (flag clear, or
  // the source is granted this very cycle), clear on a grant without reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 3'b000;
      r_hold <= 24'h000000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (src_pulse[i] && (!r_full[i] || w_grant_vec[i])) begin
          r_hold[i] <= src_code[8*i +: 8];
          r_full[i] <= 1'b1;
        end else if (w_grant_vec[i]) begin
          r_full[i] <= 1'b0;
        end else begin
          r_full[i] <= r_full[i];
        end
      end
    end
  end

  // Round-robin pointer; reset value 2 makes the first search order 0,1,2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 2'd2;
    end else if (w_push) begin
      r_ptr <= w_grant_idx;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Queue storage; contents are don't-care while not covered by r_level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_grant_code;
    end
  end

  // Queue pointers and occupancy. Pointers wrap naturally at FIFO_DEPTH
  // because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= LP_LVL_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      r_level <= w_level_next;
    end
  end

  // Interrupt follows the occupancy one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_level != LP_LVL_ZERO);
    end
  end

  // Dropped-event counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 8'h00;
    end else begin
      r_ovf <= w_ovf_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all derived directly from registers)
  // ---------------------------------------------------------------------------
  assign ev_valid   = (r_level != LP_LVL_ZERO);
  assign ev_code    = (r_level != LP_LVL_ZERO) ? r_mem[r_rd_ptr] : 8'h00;
  assign irq        = r_irq;
  assign fifo_level = r_level;
  assign ovf_cnt    = r_ovf;

endmodule

// File: tb/tb_key_event_scheduler.sv
// -----------------------------------------------------------------------------
// Self-checking bench for key_event_scheduler: directed scenarios with
// constant expectations plus a randomized run compared against a queue-based
// reference model.
// -----------------------------------------------------------------------------
module tb_key_event_scheduler;

  localparam int FIFO_DEPTH = 8;
  localparam int AW         = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    src_pulse;
  logic [23:0]   src_code;
  logic          ev_valid;
  logic [7:0]    ev_code;
  logic          ev_ack;
  logic          irq;
  logic [AW:0]   fifo_level;
  logic [7:0]    ovf_cnt;
  logic          clr_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_event_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_pulse  (src_pulse),
    .src_code   (src_code),
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_ack     (ev_ack),
    .irq        (irq),
    .fifo_level (fifo_level),
    .ovf_cnt    (ovf_cnt),
    .clr_ovf    (clr_ovf)
  );

  // ---------------------------------------------------------------------------
  // Reference model: queue of codes, per-source holds, last-granted source.
  // ---------------------------------------------------------------------------
  logic [7:0] m_q[$];
  logic [7:0] m_hold [3];
  bit         m_full [3];
  int         m_ptr;
  int         m_ovf;
  bit         m_irq;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 3; i++) begin
      m_full[i] = 1'b0;
      m_hold[i] = 8'h00;
    end
    m_ptr = 2;
    m_ovf = 0;
    m_irq = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] p, input logic [23:0] c,
                            input logic a, input logic clr);
    int  g;
    int  drops;
    bit  pop;
    bit  space;
    bit  irq_next;
    irq_next = (m_q.size() != 0);
    pop      = a && (m_q.size() != 0);
    space    = (m_q.size() < FIFO_DEPTH) || pop;
    g = -1;
    for (int k = 1; k <= 3; k++) begin
      int s;
      s = (m_ptr + k) % 3;
      if (g < 0 && m_full[s] && space) g = s;
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(m_hold[g]);
      m_full[g] = 1'b0;
      m_ptr = g;
    end
    drops = 0;
    for (int i = 0; i < 3; i++) begin
      if (p[i]) begin
        if (!m_full[i]) begin
          m_hold[i] = c[8*i +: 8];
          m_full[i] = 1'b1;
        end else begin
          drops++;
        end
      end
    end
    if (clr) m_ovf = drops;
    else     m_ovf = (m_ovf + drops > 255) ? 255 : m_ovf + drops;
    m_irq = irq_next;
  endtask

  // Apply one cycle of inputs, let the edge happen, advance the model, and
  // return 1 time unit after the edge with inputs idle.
  task automatic step(input logic [2:0] p, input logic [23:0] c,
                      input logic a, input logic clr);
    src_pulse = p;
    src_code  = c;
    ev_ack    = a;
    clr_ovf   = clr;
    @(posedge clk);
    model_step(p, c, a, clr);
    #1;
    src_pulse = 3'b000;
    src_code  = 24'h000000;
    ev_ack    = 1'b0;
    clr_ovf   = 1'b0;
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    model_reset();
    #2;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Push n events from source 0, one grant per pair of cycles.
  task automatic fill_src0(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      step(3'b001, {16'h0000, base + 8'(i)}, 1'b0, 1'b0);
      step(3'b000, 24'h000000, 1'b0, 1'b0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid got %b want 0", ev_valid); end
    checks++; if (ev_code !== 8'h00) begin errors++; $display("FAIL reset_ev_code got %h want 00", ev_code); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (ovf_cnt !== 8'h00) begin errors++; $display("FAIL reset_ovf got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_single();
    step(3'b001, 24'h000085, 1'b0, 1'b0);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_not_yet got %b want 0", ev_valid); end
    step(3'b000, 24'h000000, 1'b0, 1'b0);
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", ev_valid); end
    checks++; if (ev_code !== 8'h85) begin errors++; $display("FAIL single_code got %h want 85", ev_code); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_early got %b want 0", irq); end
    step(3'b000, 24'h000000, 1'b0, 1'b0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq got %b want 1", irq); end
    step(3'b000, 24'h000000, 1'b1, 1'b0);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_ack_valid got %b want 0", ev_valid); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL single_ack_level got %0d want 0", fifo_level); end
    step(3'b000, 24'h000000, 1'b0, 1'b0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_drop got %b want 0", irq); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_a [3];
    logic [7:0] exp_b [3];
    exp_a[0] = 8'h41; exp_a[1] = 8'hC2; exp_a[2] = 8'hC0;
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    assert_reset();
    release_reset();
    step(3'b111, 24'hC0C241, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(3'b000, 24'h000000, 1'b0, 1'b0);
    checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL rr_level got %0d want 3", fifo_level); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (ev_code !== exp_a[i]) begin errors++; $display("FAIL rr_order1[%0d] got %h want %h", i, ev_code, exp_a[i]); end
      step(3'b000, 24'h000000, 1'b1, 1'b0);
    end
    step(3'b111, 24'h332211, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(3'b000, 24'h000000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (ev_code !== exp_b[i]) begin errors++; $display("FAIL rr_order2[%0d] got %h want %h", i, ev_code, exp_b[i]); end
      step(3'b000, 24'h000000, 1'b1, 1'b0);
    end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rr_drained got %b want 0", ev_valid); end
  endtask

  task automatic test_full_queue();
    logic [7:0] exp_c [8];
    for (int i = 0; i < 7; i++) exp_c[i] = 8'h11 + 8'(i);
    exp_c[7] = 8'h99;
    assert_reset();
    release_reset();
    fill_src0(8, 8'h10);
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_level got %0d want 8", fifo_level); end
    step(3'b001, 24'h000099, 1'b0, 1'b0);
    step(3'b000, 24'h000000, 1'b0, 1'b0);
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_wait_level got %0d want 8", fifo_level); end
    checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL full_wait_ovf got %0d want 0", ovf_cnt); end
    step(3'b001, 24'h0000AA, 1'b0, 1'b0);
    checks++; if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL full_drop_ovf got %0d want 1", ovf_cnt); end
    step(3'b000, 24'h000000, 1'b1, 1'b0);
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_ack_level got %0d want 8", fifo_level); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (ev_code !== exp_c[i]) begin errors++; $display("FAIL full_order[%0d] got %h want %h", i, ev_code, exp_c[i]); end
      step(3'b000, 24'h000000, 1'b1, 1'b0);
    end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL full_drained got %0d want 0", fifo_level); end
  endtask

  task automatic test_saturation();
    assert_reset();
    release_reset();
    fill_src0(8, 8'h20);
    step(3'b111, 24'h030201, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(3'b111, 24'h060504, 1'b0, 1'b0);
    checks++; if (ovf_cnt !== 8'd30) begin errors++; $display("FAIL sat_partial got %0d want 30", ovf_cnt); end
    for (int i = 0; i < 90; i++) step(3'b111, 24'h060504, 1'b0, 1'b0);
    checks++; if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL sat_value got %0d want 255", ovf_cnt); end
    step(3'b001, 24'h000007, 1'b0, 1'b1);
    checks++; if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL sat_clear got %0d want 1", ovf_cnt); end
    step(3'b000, 24'h000000, 1'b0, 1'b1);
    checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL clr_nodrop got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_collision();
    assert_reset();
    release_reset();
    step(3'b001, 24'h0000A1, 1'b0, 1'b0);
    step(3'b001, 24'h0000A2, 1'b0, 1'b0);
    step(3'b000, 24'h000000, 1'b0, 1'b0);
    checks++; if (fifo_level !== 4'd2) begin errors++; $display("FAIL coll_level got %0d want 2", fifo_level); end
    checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL coll_ovf got %0d want 0", ovf_cnt); end
    checks++; if (ev_code !== 8'hA1) begin errors++; $display("FAIL coll_first got %h want A1", ev_code); end
    step(3'b000, 24'h000000, 1'b1, 1'b0);
    checks++; if (ev_code !== 8'hA2) begin errors++; $display("FAIL coll_second got %h want A2", ev_code); end
    step(3'b000, 24'h000000, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    assert_reset();
    release_reset();
    fill_src0(5, 8'h50);
    step(3'b110, 24'hBBAA00, 1'b0, 1'b0);
    checks++; if (fifo_level !== 4'd5) begin errors++; $display("FAIL mid_pre_level got %0d want 5", fifo_level); end
    assert_reset();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", ev_valid); end
    checks++; if (ev_code !== 8'h00) begin errors++; $display("FAIL mid_code got %h want 00", ev_code); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got %b want 0", irq); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL mid_level got %0d want 0", fifo_level); end
    checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL mid_ovf got %0d want 0", ovf_cnt); end
    release_reset();
    for (int i = 0; i < 6; i++) begin
      step(3'b000, 24'h000000, 1'b0, 1'b0);
      checks++; if (ev_valid !== 1'b0 || fifo_level !== 4'd0) begin
        errors++; $display("FAIL mid_stale[%0d] got valid %b level %0d want 0 0", i, ev_valid, fifo_level);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  p;
    logic [23:0] c;
    logic        a;
    logic        clr;
    logic [7:0]  exp_code;
    assert_reset();
    release_reset();
    for (int n = 0; n < 1500; n++) begin
      p   = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      c   = 24'($urandom());
      a   = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
      clr = ($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0;
      step(p, c, a, clr);
      exp_code = (m_q.size() != 0) ? m_q[0] : 8'h00;
      checks++; if (ev_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d got %b want %b", n, ev_valid, (m_q.size() != 0)); end
      checks++; if (ev_code !== exp_code) begin errors++; $display("FAIL rnd_code@%0d got %h want %h", n, ev_code, exp_code); end
      checks++; if (fifo_level !== 4'(m_q.size())) begin errors++; $display("FAIL rnd_level@%0d got %0d want %0d", n, fifo_level, m_q.size()); end
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq@%0d got %b want %b", n, irq, m_irq); end
      checks++; if (ovf_cnt !== 8'(m_ovf)) begin errors++; $display("FAIL rnd_ovf@%0d got %0d want %0d", n, ovf_cnt, m_ovf); end
    end
  endtask

  initial begin
    src_pulse = 3'b000;
    src_code  = 24'h000000;
    ev_ack    = 1'b0;
    clr_ovf   = 1'b0;
    assert_reset();
    test_reset();
    release_reset();
    test_single();
    test_round_robin();
    test_full_queue();
    test_saturation();
    test_collision();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
